// File: rtl/tile_ram_write_ctrl.sv
// Write-port controller for the dual-clock tile RAM: round-robin arbitration between
// game logic (A) and cursor overlay (B), plus a bulk fill engine that sweeps every address.
`timescale 1ns/1ps
module tile_ram_write_ctrl #(
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  a_valid_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  output logic                  a_ready_o,
  input  logic                  b_valid_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  output logic                  b_ready_o,
  input  logic                  fill_start_i,
  input  logic [DATA_WIDTH-1:0] fill_data_i,
  output logic                  busy_o,
  output logic                  fill_done_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;
  logic                  last_grant_q, last_grant_d;  // 1 = B was granted last
  logic                  we_d, done_d, busy_d;
  logic [ADDR_WIDTH-1:0] waddr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  last_cnt;

  // Terminal compare stops the sweep on the final word, so the address never wraps.
  assign last_cnt = (cnt_q == '1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fill_start_i) state_d = FILL;
      FILL:    if (last_cnt)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_ready_o    = 1'b0;
    b_ready_o    = 1'b0;
    we_d         = 1'b0;
    done_d       = 1'b0;
    busy_d       = (state_q == FILL);
    waddr_d      = waddr_o;
    wdata_d      = wdata_o;
    cnt_d        = cnt_q;
    fill_data_d  = fill_data_q;
    last_grant_d = last_grant_q;

    case (state_q)
      IDLE: begin
        if (fill_start_i) begin
          fill_data_d = fill_data_i;
          cnt_d       = '0;
        end else begin
          if (a_valid_i && b_valid_i) begin
            a_ready_o = last_grant_q;
            b_ready_o = !last_grant_q;
          end else begin
            a_ready_o = a_valid_i;
            b_ready_o = b_valid_i;
          end
          if (a_ready_o) begin
            we_d         = 1'b1;
            waddr_d      = a_addr_i;
            wdata_d      = a_data_i;
            last_grant_d = 1'b0;
          end else if (b_ready_o) begin
            we_d         = 1'b1;
            waddr_d      = b_addr_i;
            wdata_d      = b_data_i;
            last_grant_d = 1'b1;
          end
        end
      end
      FILL: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = fill_data_q;
        done_d  = last_cnt;
        cnt_d   = cnt_q + ADDR_WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      fill_data_q  <= '0;
      last_grant_q <= 1'b1;
      we_o         <= 1'b0;
      waddr_o      <= '0;
      wdata_o      <= '0;
      busy_o       <= 1'b0;
      fill_done_o  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      fill_data_q  <= fill_data_d;
      last_grant_q <= last_grant_d;
      we_o         <= we_d;
      waddr_o      <= waddr_d;
      wdata_o      <= wdata_d;
      busy_o       <= busy_d;
      fill_done_o  <= done_d;
    end
  end

endmodule

// File: tb/tb_tile_ram_write_ctrl.sv
// Self-checking bench for tile_ram_write_ctrl: arbitration vector table, scoreboard of
// expected RAM writes, and hand-written fill / re-trigger / reset-abort sequences.
`timescale 1ns/1ps
module tb_tile_ram_write_ctrl;
  localparam int DW    = 7;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;
  localparam int NVEC  = 13;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          a_valid_i = 1'b0, b_valid_i = 1'b0, fill_start_i = 1'b0;
  logic [AW-1:0] a_addr_i = '0, b_addr_i = '0;
  logic [DW-1:0] a_data_i = '0, b_data_i = '0, fill_data_i = '0;
  logic          a_ready_o, b_ready_o, busy_o, fill_done_o, we_o;
  logic [AW-1:0] waddr_o;
  logic [DW-1:0] wdata_o;

  tile_ram_write_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .a_valid_i(a_valid_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
    .b_valid_i(b_valid_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
    .fill_start_i(fill_start_i), .fill_data_i(fill_data_i),
    .busy_o(busy_o), .fill_done_o(fill_done_o),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          bv;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    logic          ea;
    logic          eb;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[NVEC];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entries queued before an edge are the writes that edge must register.
  task automatic tick();
    wr_t e;
    @(posedge clk_i);
    #1;
    check("we", 32'(we_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (we_o) check("write", 32'({busy_o, fill_done_o, waddr_o, wdata_o}), 32'(e));
    end else begin
      check("idle_flags", 32'({busy_o, fill_done_o}), 32'(0));
    end
  endtask

  task automatic check_ready(input string name, input logic ea, input logic eb);
    #1;
    check(name, 32'({a_ready_o, b_ready_o}), 32'({ea, eb}));
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({we_o, busy_o, fill_done_o, a_ready_o, b_ready_o}), 32'(0));
    check({name, "_addr_data"}, 32'({waddr_o, wdata_o}), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 9'h004, 7'h12, 1'b0, 9'h000, 7'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 9'h000, 7'h00, 1'b0, 9'h000, 7'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 9'h000, 7'h00, 1'b1, 9'h003, 7'h33, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 9'h001, 7'h11, 1'b1, 9'h002, 7'h22, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 9'h001, 7'h11, 1'b1, 9'h002, 7'h22, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 9'h001, 7'h11, 1'b1, 9'h002, 7'h22, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 9'h001, 7'h11, 1'b1, 9'h002, 7'h22, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 9'h000, 7'h00, 1'b0, 9'h000, 7'h00, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 9'h008, 7'h08, 1'b0, 9'h000, 7'h00, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 9'h000, 7'h00, 1'b1, 9'h009, 7'h19, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 9'h000, 7'h00, 1'b1, 9'h00A, 7'h1A, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 9'h00B, 7'h2B, 1'b1, 9'h00C, 7'h3C, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 9'h000, 7'h00, 1'b0, 9'h000, 7'h00, 1'b0, 1'b0};

    // Reset with all inputs low
    #12;
    check_all_zero("reset");
    #5 rst_ni = 1'b1;
    tick();

    // Arbitration table: A wins the first tie, then round-robin
    for (int i = 0; i < NVEC; i++) begin
      a_valid_i = vecs[i].av; a_addr_i = vecs[i].aa; a_data_i = vecs[i].ad;
      b_valid_i = vecs[i].bv; b_addr_i = vecs[i].ba; b_data_i = vecs[i].bd;
      check_ready("ready_vec", vecs[i].ea, vecs[i].eb);
      if (vecs[i].ea) exp_q.push_back('{1'b0, 1'b0, vecs[i].aa, vecs[i].ad});
      if (vecs[i].eb) exp_q.push_back('{1'b0, 1'b0, vecs[i].ba, vecs[i].bd});
      tick();
    end

    // Fill of zeros started while A is requesting; re-trigger at fill cycle 100 is ignored
    a_valid_i = 1'b1; a_addr_i = 9'h005; a_data_i = 7'h55;
    fill_start_i = 1'b1; fill_data_i = 7'h00;
    check_ready("ready_fill_start", 1'b0, 1'b0);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      fill_start_i = (i == 100);
      fill_data_i  = (i == 100) ? 7'h7F : 7'h00;
      check_ready("ready_in_fill", 1'b0, 1'b0);
      exp_q.push_back('{1'b1, (i == DEPTH - 1), AW'(i), 7'h00});
      tick();
    end
    fill_start_i = 1'b0; fill_data_i = 7'h00;
    check_ready("ready_after_fill", 1'b1, 1'b0);
    exp_q.push_back('{1'b0, 1'b0, 9'h005, 7'h55});
    tick();
    a_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Reset pulsed while address 200 is on the write port
    fill_start_i = 1'b1; fill_data_i = 7'h2A;
    check_ready("ready_fill2_start", 1'b0, 1'b0);
    tick();
    fill_start_i = 1'b0; fill_data_i = 7'h00;
    for (int i = 0; i <= 200; i++) begin
      exp_q.push_back('{1'b1, 1'b0, AW'(i), 7'h2A});
      tick();
    end
    #2 rst_ni = 1'b0;
    #1 check_all_zero("reset_mid_fill");
    #3 rst_ni = 1'b1;
    a_valid_i = 1'b1; a_addr_i = 9'h007; a_data_i = 7'h6A;
    check_ready("ready_after_abort", 1'b1, 1'b0);
    exp_q.push_back('{1'b0, 1'b0, 9'h007, 7'h6A});
    tick();
    a_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
